// File: rtl/seq_subtractor_pkg.sv
// Shared types and helpers for the chunk-serial subtractor.
package seq_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtractor: ripple of full subtractors built from half subtractors.
module chunk_subtractor #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] brw;
  logic           d1;
  logic           b1;
  logic           b2;

  // Each stage: half subtract x-y, half subtract the borrow, OR the two borrows.
  always_comb begin
    brw    = '0;
    d      = '0;
    d1     = 1'b0;
    b1     = 1'b0;
    b2     = 1'b0;
    brw[0] = bin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      d1         = x[i] ^ y[i];
      b1         = ~x[i] & y[i];
      d[i]       = d1 ^ brw[i];
      b2         = ~d1 & brw[i];
      brw[i+1]   = b1 | b2;
    end
    bout = brw[CHUNK];
  end

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor computing a - b - borrow_in, CHUNK bits per clock with a rippled borrow flop.
module seq_subtractor
  import seq_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             borrow,
  output logic             overflow
);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "seq_subtractor: illegal WIDTH/CHUNK combination");
  end

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  sub_state_t       state;
  sub_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic [CHUNK-1:0] d_chunk;
  logic             bout;
  logic             last;

  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_sh[CHUNK-1:0]),
    .y    (b_sh[CHUNK-1:0]),
    .bin  (brw),
    .d    (d_chunk),
    .bout (bout)
  );

  assign last = (cnt == CNT_W'(NCHUNK - 1));
  assign busy = (state == RUN);

  // Result fills from the top so after NCHUNK shifts chunk 0 lands in the low bits.
  always_comb begin
    r_next = (r_sh >> CHUNK) | (WIDTH'(d_chunk) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      brw      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      done     <= 1'b0;
      dif      <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          brw   <= borrow_in;
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
          cnt   <= '0;
        end
      end else begin
        a_sh <= a_sh >> CHUNK;
        b_sh <= b_sh >> CHUNK;
        r_sh <= r_next;
        brw  <= bout;
        cnt  <= cnt + 1'b1;
        if (last) begin
          dif      <= r_next;
          borrow   <= bout;
          overflow <= (a_msb ^ b_msb) & (a_msb ^ r_next[WIDTH-1]);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
